// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with glitch filter, frame decoder and event FIFO.
//   Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop),
//   folds F0 (break) and E0 (extended) prefixes into the following scan code
//   and queues {break, ext, code} events in a first-word-fall-through FIFO.
// Ports:
//   clk, rst_n           system clock, async active-low reset
//   ps2_clk, ps2_data    raw PS/2 lines (asynchronous)
//   ev_valid/ev_ready    FIFO head handshake; ev_code/ev_break/ev_ext = head
//   ev_count             events stored
//   frame_err            one-cycle pulse per rejected or timed-out frame
//   overflow, ovf_clr    sticky drop flag and its synchronous clear
//
// state     | meaning
// ST_IDLE   | waiting for start bit
// ST_SHIFT  | capturing 8 data bits, LSB first
// ST_PARITY | capturing parity bit
// ST_STOP   | checking stop bit, then decode/push
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_ext,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY, ST_STOP} state_t;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q;
  logic [FW-1:0] flt_cnt_q;
  logic          differ, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  // Down-counter of consecutive samples disagreeing with the filtered level;
  // the level flips on the FILTER_LEN-th such sample.
  assign differ = clk_sync_q[1] != filt_q;
  assign fall   = differ && (flt_cnt_q == '0) && filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= FW'(FILTER_LEN - 1);
    end else if (!differ) begin
      flt_cnt_q <= FW'(FILTER_LEN - 1);
    end else if (flt_cnt_q == '0) begin
      filt_q    <= ~filt_q;
      flt_cnt_q <= FW'(FILTER_LEN - 1);
    end else begin
      flt_cnt_q <= flt_cnt_q - 1'b1;
    end
  end

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ferr_q, ferr_d;
  logic          timeout, push;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    par_d     = par_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    ferr_d    = 1'b0;
    push      = 1'b0;
    to_cnt_d  = to_cnt_q;
    timeout   = 1'b0;

    if (state_q == ST_IDLE || fall) to_cnt_d = TW'(TIMEOUT_CYC - 1);
    else if (to_cnt_q != '0)        to_cnt_d = to_cnt_q - 1'b1;
    else                            timeout  = 1'b1;

    if (timeout) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      ferr_d    = 1'b1;
      brk_d     = 1'b0;
      ext_d     = 1'b0;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (dat_sync_q[1]) begin
            ferr_d = 1'b1;
            brk_d  = 1'b0;
            ext_d  = 1'b0;
          end else begin
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
          end
        end
        ST_SHIFT: begin
          sr_d      = {dat_sync_q[1], sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_sync_q[1];
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if ((^{sr_q, par_q}) && dat_sync_q[1]) begin
            if (sr_q == 8'hF0)      brk_d = 1'b1;
            else if (sr_q == 8'hE0) ext_d = 1'b1;
            else begin
              push  = 1'b1;
              brk_d = 1'b0;
              ext_d = 1'b0;
            end
          end else begin
            ferr_d = 1'b1;
            brk_d  = 1'b0;
            ext_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      par_q     <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      to_cnt_q  <= TW'(TIMEOUT_CYC - 1);
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      to_cnt_q  <= to_cnt_d;
      ferr_q    <= ferr_d;
    end
  end

  assign frame_err = ferr_q;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q, full, pop, do_push;

  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign pop     = ev_valid && ev_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {brk_q, ext_q, sr_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      ovf_q <= (ovf_q && !ovf_clr) || (push && full && !pop);
    end
  end

  assign ev_valid = cnt_q != '0;
  assign ev_count = cnt_q;
  assign overflow = ovf_q;
  assign ev_code  = ev_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign ev_ext   = ev_valid ? mem_q[rd_ptr_q][8]   : 1'b0;
  assign ev_break = ev_valid ? mem_q[rd_ptr_q][9]   : 1'b0;

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter FILTER_LEN, 8, number of consecutive identical synchronised samples required before the filtered ps2_clk changes level.
REQ-002 Parameter TIMEOUT_CYC, 100000, mid-frame clk cycles without a filtered ps2_clk falling edge before the frame is aborted.
REQ-003 Parameter FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  system clock; all flops rise-edge clocked.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-008 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-009 ev_valid  output  1  FIFO head holds a key event.
REQ-010 ev_ready  input  1  consumer accepts the head event when ev_valid=1.
REQ-011 ev_code  output  8  scan code of the head event.
REQ-012 ev_break  output  1  head event is a key release (F0-prefixed).
REQ-013 ev_ext  output  1  head event is an extended key (E0-prefixed).
REQ-014 ev_count  output  $clog2(FIFO_DEPTH)+1  events currently stored.
REQ-015 frame_err  output  1  one-cycle pulse per rejected frame.
REQ-016 overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-017 ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-018 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; filtered ps2_clk changes only after FILTER_LEN consecutive equal synchronised samples; glitches shorter than FILTER_LEN cycles are ignored.
REQ-019 Data SHALL be sampled from synchronised ps2_data in the cycle a filtered ps2_clk falling edge is detected.
REQ-020 Frame FSM states: IDLE, SHIFT, PARITY, STOP; IDLE->SHIFT on falling edge with data=0; IDLE on falling edge with data=1 -> frame_err pulse, stay IDLE.
REQ-021 SHIFT captures 8 bits LSB first, then ->PARITY; PARITY captures parity bit, ->STOP; STOP checks stop bit, ->IDLE.
REQ-022 Frame valid iff data bits plus parity bit contain an odd number of ones and stop bit=1; otherwise frame_err pulses once, one cycle after the stop-bit edge, and no event is generated.
REQ-023 Timeout counter resets on every filtered falling edge and in IDLE; reaching TIMEOUT_CYC outside IDLE -> frame_err pulse, FSM to IDLE, bit counter cleared.
REQ-024 Valid byte 0xF0 SHALL set the pending break flag; valid byte 0xE0 SHALL set the pending ext flag; neither is pushed.
REQ-025 Any other valid byte SHALL push {pending break, pending ext, byte} one cycle after the stop-bit edge, then clear both pending flags.
REQ-026 frame_err and timeout SHALL clear both pending flags.
REQ-027 FIFO is first-word-fall-through; ev_code/ev_break/ev_ext reflect the head whenever ev_valid=1; pop occurs on ev_valid & ev_ready.
REQ-028 Push when full without simultaneous pop: event dropped, stored contents unchanged, overflow set.
REQ-029 Simultaneous push and pop when full: both performed, ev_count unchanged, overflow unchanged.
REQ-030 Pop when empty has no effect; ev_count never wraps.
REQ-031 ovf_clr clears overflow; if an overflow occurs in the same cycle, overflow stays set.
REQ-032 Latency: stop-bit falling edge detected in cycle N -> ev_valid=1 in cycle N+1 when FIFO was empty.

Reset
REQ-033 rst_n=0 SHALL immediately force: FSM IDLE, bit/timeout counters 0, pending flags 0, FIFO empty, ev_valid=0, ev_code=0, ev_break=0, ev_ext=0, ev_count=0, frame_err=0, overflow=0, synchroniser/filter state idle-high.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release decodes normally.

Verification
REQ-035 Frame 0x1C (parity 0, stop 1), 43.2 us half-bit, 50 MHz clk -> one event: ev_code=0x1C, ev_break=0, ev_ext=0, frame_err never asserted.
REQ-036 Frames F0, 1C -> exactly one event: ev_code=0x1C, ev_break=1, ev_ext=0.
REQ-037 Frames E0, F0, 75 -> exactly one event: ev_code=0x75, ev_ext=1, ev_break=1.
REQ-038 Frame 0x1C with parity=1, then good 0x1C -> one frame_err pulse, then single event 0x1C; 3-cycle ps2_clk glitch in between -> no effect.
REQ-039 Stop after 5 data bits, idle > TIMEOUT_CYC -> one frame_err pulse, FSM IDLE; next frame 0x1C decoded correctly.
REQ-040 Nine frames 0x01..0x09 with ev_ready=0, FIFO_DEPTH=8 -> ev_count=8, overflow=1; draining yields 0x01..0x08 in order; ovf_clr -> overflow=0.
